// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin merge of the IM/DM cache channels onto one fixed-latency SRAM port
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_enable,
  input  logic              IM_read,
  input  logic              IM_write,
  input  logic [ADDR_W-1:0] IM_address,
  output logic              IM_ready,
  output logic [31:0]       instruction,
  input  logic              DM_enable,
  input  logic              DM_read,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [31:0]       DM_in,
  output logic              DM_ready,
  output logic [31:0]       DM_out,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W:0]   mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, TURN} state_t;
  state_t            state, next;
  logic [3:0]        cnt;
  logic              last_grant, grant, wr, pick_dm, unused_ok;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  // DM wins when alone, or on a tie when IM was served last (last_grant: 1 = DM)
  assign pick_dm   = DM_enable & (~IM_enable | ~last_grant);
  assign unused_ok = IM_read ^ IM_write;
  // state register
  always_ff @(posedge clk)
    state <= !rst ? IDLE : next;
  // next-state and port outputs; SRAM strobes only while accessing, ready only in RESP
  always_comb begin
    next        = state;
    IM_ready    = 1'b0;
    DM_ready    = 1'b0;
    mem_enable  = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    busy        = state != IDLE;
    case (state)
      IDLE:   next = (IM_enable | DM_enable) ? ACCESS : IDLE;
      ACCESS: begin
        mem_enable  = 1'b1;
        mem_write   = wr;
        mem_address = {grant, addr};
        mem_wdata   = wdata;
        next        = cnt == '0 ? RESP : ACCESS;
      end
      RESP: begin
        IM_ready = ~grant;
        DM_ready = grant;
        next     = TURN;
      end
      TURN:   next = IDLE;
    endcase
  end
  // request latch on grant, wait countdown, read-data capture and round-robin history
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      last_grant  <= 1'b0;
      grant       <= 1'b0;
      addr        <= '0;
      wr          <= 1'b0;
      wdata       <= '0;
      instruction <= '0;
      DM_out      <= '0;
    end else if (state == IDLE && (IM_enable | DM_enable)) begin
      grant <= pick_dm;
      addr  <= pick_dm ? DM_address : IM_address;
      wr    <= pick_dm & DM_write & ~DM_read;
      wdata <= DM_in;
      cnt   <= 4'(WAIT_CYCLES - 1);
    end else if (state == ACCESS) begin
      if (cnt == '0) begin
        last_grant <= grant;
        if (!wr && grant) DM_out <= mem_rdata;
        if (!grant) instruction <= mem_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end
endmodule
